bus_arbiter_rr: RTL
===================

Name: bus_arbiter_rr

Overview:
- N-master system-bus arbiter; parametrised successor of the two-master fixed-priority arbiter.
- Selects one requesting master, either by round-robin or by fixed priority.
- Captures the winner's serially transmitted slave address, then drives one-hot grants and mux selects until trans_done.
- Sits between the masters' request/address lines and the address/data muxes feeding the slaves.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- SLAVE_ADDR_W, 2, width of the serial slave select, shifted in LSB first (1..4).
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT_CYCLES, 255, BUSY-state watchdog limit; used only with ARB_TIMEOUT_EN (1..65535).
- Derived: GW = $clog2(NUM_MASTERS+1).

Ports:
- sys_clk  in  1  system clock, shared by all masters.
- sys_rst  in  1  asynchronous, active-high reset.
- m_request  in  NUM_MASTERS  per-master bus request; held high until grant.
- m_slave_sel  in  NUM_MASTERS  per-master serial slave-address bit.
- trans_done  in  1  slave/master end-of-transaction pulse.
- m_grant  out  NUM_MASTERS  one-hot grant.
- bus_grant  out  GW  encoded owner to mux: master index+1; 0 = none.
- slave_sel  out  SLAVE_ADDR_W  captured slave address to mux.
- arbiter_busy  out  1  high while address capture is in progress.
- bus_busy  out  1  high while the bus is owned.
- timeout  out  1  one-cycle watchdog pulse; constant 0 without the macro.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE. All of the following are 0: m_grant, bus_grant, slave_sel, arbiter_busy, bus_busy, timeout, bit counter, address shift register. Round-robin pointer last_idx = NUM_MASTERS-1, so master 0 wins first. Reset mid-transaction drops the grant at once; no trans_done is needed.
- All outputs are registered.
- IDLE:
  - If m_request == 0, stay in IDLE; arbiter_busy = 0.
  - Otherwise select winner w.
    - PRIORITY_MODE = 0: first set bit searching last_idx+1, last_idx+2, … modulo NUM_MASTERS.
    - PRIORITY_MODE = 1: lowest set index.
  - Latch w and sample m_slave_sel[w] into addr bit 0; arbiter_busy = 1.
  - If SLAVE_ADDR_W == 1, go straight to grant (see below); else go to ADDR with count = 1.
- ADDR:
  - Each edge samples m_slave_sel[w] into addr bit [count], then count++.
  - Other masters' requests are ignored.
  - If m_request[w] == 0 at any ADDR edge: abort to IDLE. arbiter_busy = 0, no grant, last_idx unchanged, partial address discarded.
- Grant is issued at the edge that samples bit SLAVE_ADDR_W-1:
  - m_grant = 1<<w; bus_grant = w+1; slave_sel = full address.
  - arbiter_busy = 0, bus_busy = 1; last_idx = w; go to BUSY.
- Latency: request sampled at edge 0 -> grant outputs valid after edge SLAVE_ADDR_W-1 (SLAVE_ADDR_W cycles).
- BUSY:
  - Hold all grant outputs.
  - trans_done = 1 -> IDLE; m_grant = 0, bus_grant = 0, bus_busy = 0; slave_sel holds its last value.
  - New requests are not evaluated in the same cycle. Earliest re-arbitration is the next edge, which gives the bus one idle cycle.
- trans_done outside BUSY is ignored.
- Requests arriving during ADDR/BUSY wait; there is no preemption.
- Round-robin fairness: with all masters requesting continuously, grants rotate 0,1,2,…,N-1,0.
- Invariants (assert in bench):
  - m_grant is one-hot or zero.
  - bus_busy == |m_grant.
  - arbiter_busy and bus_busy are never both 1.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on BUSY entry and increments each BUSY cycle without trans_done.
  - When the counter reaches TIMEOUT_CYCLES, force IDLE exactly as for trans_done (grants cleared, last_idx kept) and pulse timeout for 1 cycle.
  - trans_done on the same edge takes precedence; timeout stays 0.
- Undefined: no counter is built; BUSY waits indefinitely; timeout is tied to 0.

Test Plan:
- Reset then m_request = 4'b0001, m_slave_sel serial 1,0 (addr 2'b01) -> after edge 1: m_grant = 0001, bus_grant = 1, slave_sel = 01, bus_busy = 1; arbiter_busy = 1 for exactly 1 cycle.
- All four requesting, trans_done pulsed 3 cycles after each grant, PRIORITY_MODE = 0 -> bus_grant sequence 1,2,3,4,1. With PRIORITY_MODE = 1 -> 1,1,1,1.
- Master 2 request drops during ADDR -> no grant, return to IDLE, pointer unchanged; a later request from masters 1 and 2 grants master 1 first.
- Assert sys_rst asynchronously mid-BUSY -> all outputs 0 before the next edge; after release, master 0 has first priority.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 10, no trans_done -> grant released and timeout = 1 for 1 cycle, 10 cycles after grant; trans_done on cycle 10 -> normal release, timeout stays 0.
- trans_done pulsed while IDLE with no requests -> no state change, all outputs remain 0.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master round-robin/fixed-priority bus arbiter with serial slave-address capture.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int SLAVE_ADDR_W = 2,
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int GW = $clog2(NUM_MASTERS + 1)
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [NUM_MASTERS-1:0]  m_request,
  input  logic [NUM_MASTERS-1:0]  m_slave_sel,
  input  logic                    trans_done,
  output logic [NUM_MASTERS-1:0]  m_grant,
  output logic [GW-1:0]           bus_grant,
  output logic [SLAVE_ADDR_W-1:0] slave_sel,
  output logic                    arbiter_busy,
  output logic                    bus_busy,
  output logic                    timeout
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = (SLAVE_ADDR_W > 1) ? $clog2(SLAVE_ADDR_W) : 1;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || SLAVE_ADDR_W < 1 || SLAVE_ADDR_W > 4 ||
      PRIORITY_MODE < 0 || PRIORITY_MODE > 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("bus_arbiter_rr: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ADDR, BUSY} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           win_q, win_d, last_q, last_d, w, gi;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SLAVE_ADDR_W-1:0] addr_q, addr_d, ssel_q, ssel_d, ga;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [GW-1:0]           bgrant_q, bgrant_d;
  logic                    abusy_q, abusy_d, bbusy_q, bbusy_d, timeout_q, timeout_d, issue, rel;
`ifdef ARB_TIMEOUT_EN
  logic [15:0]             tcnt_q, tcnt_d;
`endif

  // Descending scan so the last hit is the highest-priority candidate.
  always_comb begin
    w = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      int idx;
      idx = (PRIORITY_MODE != 0) ? k - 1 : (int'(last_q) + k) % NUM_MASTERS;
      if (m_request[idx[IW-1:0]]) w = idx[IW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    win_d = win_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    last_d = last_q;
    grant_d = grant_q;
    bgrant_d = bgrant_q;
    ssel_d = ssel_q;
    abusy_d = abusy_q;
    bbusy_d = bbusy_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tcnt_d = tcnt_q;
`endif
    issue = 1'b0;
    rel = 1'b0;
    gi = win_q;
    ga = addr_q;
    case (state_q)
      IDLE: if (|m_request) begin
        gi = w;
        win_d = w;
        ga = '0;
        ga[0] = m_slave_sel[w];
        addr_d = ga;
        issue = SLAVE_ADDR_W == 1;
        abusy_d = SLAVE_ADDR_W != 1;
        cnt_d = CW'(1);
        state_d = ADDR;
      end
      ADDR: if (!m_request[win_q]) begin
        state_d = IDLE;
        abusy_d = 1'b0;
        addr_d = '0;
        cnt_d = '0;
      end else begin
        ga[cnt_q] = m_slave_sel[win_q];
        addr_d = ga;
        cnt_d = cnt_q + 1'b1;
        issue = cnt_q == CW'(SLAVE_ADDR_W - 1);
      end
      BUSY: begin
        rel = trans_done;
`ifdef ARB_TIMEOUT_EN
        tcnt_d = tcnt_q + 16'd1;
        if (!trans_done && tcnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          rel = 1'b1;
          timeout_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      grant_d = NUM_MASTERS'(1) << gi;
      bgrant_d = GW'(gi) + GW'(1);
      ssel_d = ga;
      abusy_d = 1'b0;
      bbusy_d = 1'b1;
      last_d = gi;
      cnt_d = '0;
      state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
      tcnt_d = '0;
`endif
    end
    if (rel) begin
      grant_d = '0;
      bgrant_d = '0;
      bbusy_d = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      win_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      last_q <= IW'(NUM_MASTERS - 1);
      grant_q <= '0;
      bgrant_q <= '0;
      ssel_q <= '0;
      abusy_q <= 1'b0;
      bbusy_q <= 1'b0;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tcnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      last_q <= last_d;
      grant_q <= grant_d;
      bgrant_q <= bgrant_d;
      ssel_q <= ssel_d;
      abusy_q <= abusy_d;
      bbusy_q <= bbusy_d;
      timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      tcnt_q <= tcnt_d;
`endif
    end
  end

  assign m_grant = grant_q;
  assign bus_grant = bgrant_q;
  assign slave_sel = ssel_q;
  assign arbiter_busy = abusy_q;
  assign bus_busy = bbusy_q;
  assign timeout = timeout_q;
endmodule
